// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch sequencer.
//   fetch_state_t : sequencer states (IDLE, REQ, WAIT, HOLD, DROP)
//   PC_STEP       : byte increment between sequential fetches
//   ALIGN_MASK    : clears the low two bits of redirect / trap targets
package fetch_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        HOLD = 3'd3,
        DROP = 3'd4
    } fetch_state_t;

    localparam logic [31:0] PC_STEP    = 32'd4;
    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/fetch_if.sv
// fetch_if: groups the imem port and the decode-side instruction slot.
//   master : fetch_ctrl side (drives imem request and the instruction slot)
//   slave  : memory / decode side
//   imem_req_o, imem_addr_o, imem_gnt_i, imem_rvalid_i, imem_rdata_i : imem port
//   inst_valid_o, inst_o, inst_pc_o, dec_ready_i                     : decode handshake
interface fetch_if #(
    parameter int ADDR_WIDTH = 16
) ();
    logic                  imem_req_o;
    logic [ADDR_WIDTH-1:0] imem_addr_o;
    logic                  imem_gnt_i;
    logic                  imem_rvalid_i;
    logic [31:0]           imem_rdata_i;
    logic                  inst_valid_o;
    logic [31:0]           inst_o;
    logic [31:0]           inst_pc_o;
    logic                  dec_ready_i;

    modport master (
        output imem_req_o, imem_addr_o, inst_valid_o, inst_o, inst_pc_o,
        input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, dec_ready_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o, inst_valid_o, inst_o, inst_pc_o,
        output imem_gnt_i, imem_rvalid_i, imem_rdata_i, dec_ready_i
    );
endinterface

// File: rtl/fetch_npc_sel.sv
// fetch_npc_sel: combinational next-PC selection.
//   Priority: reset vector > trap (FETCH_TRAP_EN) > redirect > pc+4 > hold.
//   rst_n        in  : reset (active low), selects RESET_VECTOR
//   trap_valid/trap_vec in : trap redirect (only when FETCH_TRAP_EN is defined)
//   redir_valid/redir_addr in : branch/jump redirect
//   incr         in  : a fetched word is being accepted, advance sequentially
//   pc_q         in  : current PC
//   pc_d         out : next PC
//   redirect     out : a trap or redirect is taking effect this cycle
module fetch_npc_sel
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        rst_n,
`ifdef FETCH_TRAP_EN
    input  logic        trap_valid,
    input  logic [31:0] trap_vec,
`endif
    input  logic        redir_valid,
    input  logic [31:0] redir_addr,
    input  logic        incr,
    input  logic [31:0] pc_q,
    output logic [31:0] pc_d,
    output logic        redirect
);

    always_comb begin
        pc_d     = pc_q;
        redirect = 1'b0;
        if (!rst_n) begin
            pc_d = RESET_VECTOR;
`ifdef FETCH_TRAP_EN
        end else if (trap_valid) begin
            pc_d     = trap_vec & ALIGN_MASK;
            redirect = 1'b1;
`endif
        end else if (redir_valid) begin
            pc_d     = redir_addr & ALIGN_MASK;
            redirect = 1'b1;
        end else if (incr) begin
            pc_d = pc_q + PC_STEP;  // wraps silently at 2^32
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer. Owns the PC, issues one imem
// request at a time and presents each fetched word with its PC to decode.
// Optional feature macro: FETCH_TRAP_EN (adds trap_valid_i / trap_vec_i).
//   clk_sys_i, rst_sys_n_i : clock, synchronous active-low reset
//   bus (fetch_if.master)  : imem port and decode instruction slot
//   redir_valid_i/redir_addr_i : branch/jump redirect pulse and target
//   trap_valid_i/trap_vec_i    : trap redirect (FETCH_TRAP_EN only)
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          ADDR_WIDTH   = 16
) (
    input  logic        clk_sys_i,
    input  logic        rst_sys_n_i,
    fetch_if.master     bus,
`ifdef FETCH_TRAP_EN
    input  logic        trap_valid_i,
    input  logic [31:0] trap_vec_i,
`endif
    input  logic        redir_valid_i,
    input  logic [31:0] redir_addr_i
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         inst_valid_q, inst_valid_d;
    logic [31:0]  inst_q, inst_d;
    logic [31:0]  inst_pc_q, inst_pc_d;
    logic         redirect;
    logic         incr;

    // Raw "word arrives in WAIT"; the selector lets a redirect override it.
    assign incr = (state_q == WAIT) && bus.imem_rvalid_i;

    fetch_npc_sel #(.RESET_VECTOR(RESET_VECTOR)) u_npc_sel (
        .rst_n       (rst_sys_n_i),
`ifdef FETCH_TRAP_EN
        .trap_valid  (trap_valid_i),
        .trap_vec    (trap_vec_i),
`endif
        .redir_valid (redir_valid_i),
        .redir_addr  (redir_addr_i),
        .incr        (incr),
        .pc_q        (pc_q),
        .pc_d        (pc_d),
        .redirect    (redirect)
    );

    always_comb begin
        state_d      = state_q;
        inst_valid_d = inst_valid_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        if (redirect) begin
            inst_valid_d = 1'b0;
            // A granted-but-unanswered request must still be drained in DROP.
            case (state_q)
                REQ:     state_d = bus.imem_gnt_i   ? DROP : REQ;
                WAIT:    state_d = bus.imem_rvalid_i ? REQ : DROP;
                DROP:    state_d = bus.imem_rvalid_i ? REQ : DROP;
                default: state_d = REQ;
            endcase
        end else begin
            case (state_q)
                IDLE: state_d = REQ;
                REQ:  if (bus.imem_gnt_i) state_d = WAIT;
                WAIT: if (bus.imem_rvalid_i) begin
                    inst_d       = bus.imem_rdata_i;
                    inst_pc_d    = pc_q;
                    inst_valid_d = 1'b1;
                    state_d      = HOLD;
                end
                HOLD: if (inst_valid_q && bus.dec_ready_i) begin
                    inst_valid_d = 1'b0;
                    state_d      = REQ;
                end
                DROP: if (bus.imem_rvalid_i) state_d = REQ;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_sys_i) begin
        pc_q <= pc_d;  // pc_d already resolves to RESET_VECTOR under reset
        if (!rst_sys_n_i) begin
            state_q      <= IDLE;
            inst_valid_q <= 1'b0;
            inst_q       <= '0;
            inst_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
        end
    end

    assign bus.imem_req_o   = (state_q == REQ);
    assign bus.imem_addr_o  = pc_q[ADDR_WIDTH-1:0];
    assign bus.inst_valid_o = inst_valid_q;
    assign bus.inst_o       = inst_q;
    assign bus.inst_pc_o    = inst_pc_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomised bench for fetch_ctrl with a transaction-level reference model
// and a scoreboard of expected (pc, word) pairs checked at decode.
module tb_fetch_ctrl;

    localparam logic [31:0] RV = 32'h0000_0200;
    localparam int NCYC = 4000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redir_valid;
    logic [31:0] redir_addr;
`ifdef FETCH_TRAP_EN
    logic        trap_valid;
    logic [31:0] trap_vec;
`endif
    logic        thr_phase;

    always #5 clk = ~clk;

    fetch_if #(.ADDR_WIDTH(16)) bus ();

    fetch_ctrl #(.RESET_VECTOR(RV), .ADDR_WIDTH(16)) dut (
        .clk_sys_i     (clk),
        .rst_sys_n_i   (rst_n),
        .bus           (bus),
`ifdef FETCH_TRAP_EN
        .trap_valid_i  (trap_valid),
        .trap_vec_i    (trap_vec),
`endif
        .redir_valid_i (redir_valid),
        .redir_addr_i  (redir_addr)
    );

    int checks = 0;
    int passes = 0;
    int consumed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return {a, ~a} ^ 32'h5A3C_96E1;
    endfunction

    // Scoreboard: PCs of fetches that were granted and not yet killed/consumed.
    logic [31:0] exp_q[$];
    logic [31:0] exp_addr = RV;

    // Reference model: next fetch address is sequential unless redirected;
    // a redirect/trap kills whatever has not reached decode.
    logic        s_rst, s_req, s_gnt, s_redir;
    logic [15:0] s_addr;
    logic [31:0] s_tgt;
    always begin
        @(negedge clk);
        s_rst   = rst_n;
        s_req   = bus.imem_req_o;
        s_gnt   = bus.imem_gnt_i;
        s_addr  = bus.imem_addr_o;
        s_redir = redir_valid;
        s_tgt   = {redir_addr[31:2], 2'b00};
`ifdef FETCH_TRAP_EN
        if (trap_valid) begin
            s_redir = 1'b1;
            s_tgt   = {trap_vec[31:2], 2'b00};
        end
`endif
        #1;
        if (!s_rst) begin
            exp_q.delete();
            exp_addr = RV;
        end else begin
            if (s_req && s_gnt) begin
                chk("fetch_addr", {16'h0, s_addr}, {16'h0, exp_addr[15:0]});
                if (!s_redir) begin
                    exp_q.push_back(exp_addr);
                    exp_addr = exp_addr + 32'd4;
                end
            end
            if (s_redir) begin
                exp_q.delete();
                exp_addr = s_tgt;
            end
        end
    end

    // Monitor: compares decode-side outputs against the scoreboard.
    int          cyc = 0;
    int          last_cons = -1;
    logic        prev_rst_low = 1'b0;
    logic        prev_hold = 1'b0;
    logic [31:0] prev_inst, prev_pc;
    logic [31:0] pc_e;
    logic        kill;
    always begin
        @(negedge clk);
        cyc++;
        if (prev_rst_low) begin
            chk("rst_req",   {31'h0, bus.imem_req_o},   32'h0);
            chk("rst_valid", {31'h0, bus.inst_valid_o}, 32'h0);
            chk("rst_inst",  bus.inst_o,    32'h0);
            chk("rst_pc",    bus.inst_pc_o, 32'h0);
        end
        if (prev_hold) begin
            chk("hold_valid", {31'h0, bus.inst_valid_o}, 32'h1);
            chk("hold_inst",  bus.inst_o,    prev_inst);
            chk("hold_pc",    bus.inst_pc_o, prev_pc);
            chk("hold_noreq", {31'h0, bus.imem_req_o}, 32'h0);
        end
        if (rst_n && bus.inst_valid_o && bus.dec_ready_i) begin
            chk("sb_nonempty", {31'h0, (exp_q.size() != 0)}, 32'h1);
            if (exp_q.size() != 0) begin
                pc_e = exp_q.pop_front();
                chk("inst_pc", bus.inst_pc_o, pc_e);
                chk("inst",    bus.inst_o,    mem_word(pc_e[15:0]));
            end
            consumed++;
            if (thr_phase && last_cons >= 0)
                chk("throughput_le4", {31'h0, (cyc - last_cons <= 4)}, 32'h1);
            last_cons = thr_phase ? cyc : -1;
        end
        kill = redir_valid;
`ifdef FETCH_TRAP_EN
        kill = kill | trap_valid;
`endif
        prev_rst_low = !rst_n;
        prev_hold    = rst_n && bus.inst_valid_o && !bus.dec_ready_i && !kill;
        prev_inst    = bus.inst_o;
        prev_pc      = bus.inst_pc_o;
    end

    // Stimulus: imem responder plus random decode/redirect traffic.
    logic        g, pend;
    logic [15:0] a, pend_a;
    int          dly;
    logic [31:0] picks [4];
    initial begin
        picks[0] = 32'h0000_1002;
        picks[1] = 32'hFFFF_FFF8;
        picks[2] = 32'hFFFF_FFFE;
        picks[3] = 32'h0000_0040;
        rst_n = 1'b0; redir_valid = 1'b0; redir_addr = '0; thr_phase = 1'b0;
        bus.imem_gnt_i = 1'b0; bus.imem_rvalid_i = 1'b0; bus.imem_rdata_i = '0;
        bus.dec_ready_i = 1'b0;
`ifdef FETCH_TRAP_EN
        trap_valid = 1'b0; trap_vec = '0;
`endif
        pend = 1'b0; dly = 0; pend_a = '0;
        for (int c = 0; c < NCYC; c++) begin
            @(negedge clk);
            g = bus.imem_req_o & bus.imem_gnt_i;
            a = bus.imem_addr_o;
            @(posedge clk);
            #1;
            thr_phase = (c >= 3 && c < 40);
            if (g) begin
                pend   = 1'b1;
                pend_a = a;
                dly    = thr_phase ? 0 : int'($urandom_range(0, 2));
            end
            bus.imem_rvalid_i = pend && (dly == 0);
            bus.imem_rdata_i  = bus.imem_rvalid_i ? mem_word(pend_a) : $urandom;
            if (pend) begin
                if (dly == 0) pend = 1'b0;
                else dly--;
            end
            // Second reset lands mid-traffic so a stray response hits IDLE.
            rst_n = !(c < 3 || (c >= 1500 && c < 1505));
            if (c < 40) begin
                bus.imem_gnt_i  = 1'b1;
                bus.dec_ready_i = 1'b1;
                redir_valid     = 1'b0;
            end else begin
                bus.imem_gnt_i  = ($urandom_range(0, 3) != 0);
                bus.dec_ready_i = ($urandom_range(0, 9) < 6);
                redir_valid     = ($urandom_range(0, 11) == 0);
                redir_addr      = ($urandom_range(0, 1) == 0) ? picks[$urandom_range(0, 3)] : $urandom;
`ifdef FETCH_TRAP_EN
                trap_valid = ($urandom_range(0, 23) == 0);
                trap_vec   = ($urandom_range(0, 1) == 0) ? 32'h0000_0080 : $urandom;
`endif
            end
        end
        redir_valid = 1'b0;
`ifdef FETCH_TRAP_EN
        trap_valid = 1'b0;
`endif
        @(negedge clk);
        @(negedge clk);
        chk("progress", {31'h0, (consumed > 100)}, 32'h1);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
